// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bundle: divided clock inputs, buttons and switches in;
// time fields and display blanking controls out.
interface stopwatch_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             clk_1hz;
  logic             clk_2hz;
  logic             clk_4hz;
  logic             btn_pause;
  logic             btn_clr;
  logic             sw_adj;
  logic             sw_sel;
  logic [CNT_W-1:0] sec;
  logic [CNT_W-1:0] min;
  logic             paused;
  logic             blank_sec;
  logic             blank_min;

  // Stimulus side: drives the wave/button/switch inputs, observes the display outputs.
  modport master (
    output clk_1hz, clk_2hz, clk_4hz, btn_pause, btn_clr, sw_adj, sw_sel,
    input  sec, min, paused, blank_sec, blank_min
  );

  // Controller side.
  modport slave (
    input  clk_1hz, clk_2hz, clk_4hz, btn_pause, btn_clr, sw_adj, sw_sel,
    output sec, min, paused, blank_sec, blank_min
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller and MM:SS time counter.
// Rising edges of the divided waves and the buttons are turned into registered
// one-cycle ticks; the count and mode FSM act on those ticks one cycle later.
module stopwatch_ctrl #(
  parameter int MAX_SEC = 59,
  parameter int MAX_MIN = 59,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);

  // Mode encoding; the unused code recovers to RUN.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_ADJ   = 2'd2;

  localparam logic [CNT_W-1:0] SEC_MAX_C = CNT_W'(MAX_SEC);
  localparam logic [CNT_W-1:0] MIN_MAX_C = CNT_W'(MAX_MIN);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);

  // Increment with wrap back to zero once the terminal value is reached.
  function automatic logic [CNT_W-1:0] wrap_inc(
    input logic [CNT_W-1:0] val,
    input logic [CNT_W-1:0] lim
  );
    if (val == lim) begin
      wrap_inc = ZERO_C;
    end else begin
      wrap_inc = val + ONE_C;
    end
  endfunction

  // Edge-detect history and registered ticks
  logic prev_1hz_r, prev_2hz_r, prev_pause_r, prev_clr_r;
  logic tick_1hz_r, tick_2hz_r, tick_pause_r, tick_clr_r;
  logic clk_4hz_q_r;

  // Mode and count state
  logic [1:0]       state_r, state_nxt_s;
  logic [1:0]       resume_r, resume_nxt_s;
  logic [CNT_W-1:0] sec_r, sec_nxt_s;
  logic [CNT_W-1:0] min_r, min_nxt_s;

  // Registered outputs
  logic paused_r, blank_sec_r, blank_min_r;

  // Sample inputs once and form rising-edge ticks (held levels act only once).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_1hz_r   <= 1'b0;
      prev_2hz_r   <= 1'b0;
      prev_pause_r <= 1'b0;
      prev_clr_r   <= 1'b0;
      tick_1hz_r   <= 1'b0;
      tick_2hz_r   <= 1'b0;
      tick_pause_r <= 1'b0;
      tick_clr_r   <= 1'b0;
      clk_4hz_q_r  <= 1'b0;
    end else begin
      prev_1hz_r   <= bus.clk_1hz;
      prev_2hz_r   <= bus.clk_2hz;
      prev_pause_r <= bus.btn_pause;
      prev_clr_r   <= bus.btn_clr;
      tick_1hz_r   <= bus.clk_1hz   & ~prev_1hz_r;
      tick_2hz_r   <= bus.clk_2hz   & ~prev_2hz_r;
      tick_pause_r <= bus.btn_pause & ~prev_pause_r;
      tick_clr_r   <= bus.btn_clr   & ~prev_clr_r;
      clk_4hz_q_r  <= bus.clk_4hz;
    end
  end

  // Mode transitions; ADJUST remembers which mode to go back to.
  always_comb begin
    state_nxt_s  = state_r;
    resume_nxt_s = resume_r;
    case (state_r)
      ST_RUN: begin
        if (bus.sw_adj) begin
          state_nxt_s  = ST_ADJ;
          resume_nxt_s = ST_RUN;
        end else if (tick_pause_r) begin
          state_nxt_s = ST_PAUSE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (bus.sw_adj) begin
          state_nxt_s  = ST_ADJ;
          resume_nxt_s = ST_PAUSE;
        end else if (tick_pause_r) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_ADJ: begin
        // Pause presses are ignored here; resume stays as captured on entry.
        if (!bus.sw_adj) begin
          state_nxt_s = resume_r;
        end else begin
          state_nxt_s = ST_ADJ;
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        resume_nxt_s = ST_RUN;
      end
    endcase
  end

  // Count update: clear wins over any tick; the count acts on the current mode,
  // so a tick coinciding with a mode change still applies.
  always_comb begin
    sec_nxt_s = sec_r;
    min_nxt_s = min_r;
    if (tick_clr_r) begin
      sec_nxt_s = ZERO_C;
      min_nxt_s = ZERO_C;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (tick_1hz_r) begin
            if (sec_r == SEC_MAX_C) begin
              sec_nxt_s = ZERO_C;
              min_nxt_s = wrap_inc(min_r, MIN_MAX_C);
            end else begin
              sec_nxt_s = sec_r + ONE_C;
              min_nxt_s = min_r;
            end
          end else begin
            sec_nxt_s = sec_r;
            min_nxt_s = min_r;
          end
        end
        ST_ADJ: begin
          // Field adjust wraps independently; no carry between fields.
          if (tick_2hz_r) begin
            if (bus.sw_sel) begin
              min_nxt_s = wrap_inc(min_r, MIN_MAX_C);
            end else begin
              sec_nxt_s = wrap_inc(sec_r, SEC_MAX_C);
            end
          end else begin
            sec_nxt_s = sec_r;
            min_nxt_s = min_r;
          end
        end
        default: begin
          sec_nxt_s = sec_r;
          min_nxt_s = min_r;
        end
      endcase
    end
  end

  // Mode and count registers; reset returns to 00:00 in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RUN;
      resume_r <= ST_RUN;
      sec_r    <= ZERO_C;
      min_r    <= ZERO_C;
    end else begin
      state_r  <= state_nxt_s;
      resume_r <= resume_nxt_s;
      sec_r    <= sec_nxt_s;
      min_r    <= min_nxt_s;
    end
  end

  // Status and blink outputs, built from the next mode so they line up with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paused_r    <= 1'b0;
      blank_sec_r <= 1'b0;
      blank_min_r <= 1'b0;
    end else begin
      paused_r    <= (state_nxt_s == ST_PAUSE);
      blank_sec_r <= (state_nxt_s == ST_ADJ) & ~bus.sw_sel & clk_4hz_q_r;
      blank_min_r <= (state_nxt_s == ST_ADJ) &  bus.sw_sel & clk_4hz_q_r;
    end
  end

  assign bus.sec       = sec_r;
  assign bus.min       = min_r;
  assign bus.paused    = paused_r;
  assign bus.blank_sec = blank_sec_r;
  assign bus.blank_min = blank_min_r;

endmodule
